// File: rtl/pts_tx_ctrl.sv
// pts_tx_ctrl
//   Transmit sequencer for a flex_pts_sr shift register used LSB-first
//   (NUM_BITS = FRAME_BITS, SHIFT_MSB = 0). One data word is accepted per
//   valid/ready handshake. It is framed as start(0), data LSB-first, optional
//   even parity, and stop(1). The controller then drives load_enable,
//   shift_enable and parallel_in so that the shifter's serial_out holds each
//   bit for CLKS_PER_BIT clocks.
//
// Handshake: a word transfers in any cycle where tx_valid && tx_ready.
//   tx_ready is high only in IDLE. tx_valid and tx_data are ignored in every
//   other state, so a requester may change them freely while a frame is sent.
//
// Ports
//   clk, n_rst    clock (rising edge), asynchronous active-low reset
//   tx_valid      requester has a word on tx_data
//   tx_data       payload word (DATA_BITS)
//   tx_ready      controller can accept a word this cycle
//   load_enable   shifter: load parallel_in (one cycle per frame)
//   shift_enable  shifter: shift one bit toward serial_out
//   parallel_in   shifter: frame {stop,[parity],data,start}, held between loads
//   busy          frame in progress (state != IDLE)
//   frame_done    one-cycle pulse after the final shift
module pts_tx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  localparam int FRAME_BITS  = DATA_BITS + 2 + PARITY_EN
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tx_valid,
  input  logic [DATA_BITS-1:0]  tx_data,
  output logic                  tx_ready,
  output logic                  load_enable,
  output logic                  shift_enable,
  output logic [FRAME_BITS-1:0] parallel_in,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   new_frame;

  // Frame as the shifter sees it: bit 0 leaves first, so the start bit sits
  // at the bottom and the stop bit at the top.
  generate
    if (PARITY_EN != 0) begin : g_par
      assign new_frame = {1'b1, ^tx_data, tx_data, 1'b0};
    end else begin : g_nopar
      assign new_frame = {1'b1, tx_data, 1'b0};
    end
  endgenerate

  // State register. The frame register resets to all ones to match the
  // shifter's idle-high reset contents.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      frame_q   <= '1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          frame_d = new_frame;
          state_d = LOAD;
        end
      end
      LOAD: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = SEND;
      end
      SEND: begin
        if (clk_cnt_q == LAST_CLK) begin
          // This cycle carries a shift pulse; the FRAME_BITS-th one
          // retires the stop bit and ends the frame.
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, from registered state and counters only.
  always_comb begin
    tx_ready     = 1'b0;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    parallel_in  = frame_q;
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      LOAD: begin
        load_enable = 1'b1;
      end
      SEND: begin
        shift_enable = (clk_cnt_q == LAST_CLK);
      end
      DONE: begin
        frame_done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Testbench for pts_tx_ctrl. Three instances cover the configurations of
// interest: u0 (8 data bits, 10 clk/bit, no parity), u1 (same, with parity),
// and u2 (1 data bit, 2 clk/bit). Each instance drives a behavioural
// LSB-first shifter. The reference model describes a frame by its accept
// cycle T. Every expected output is then plain arithmetic on (cycle - T).
module tb_pts_tx_ctrl;

  logic       clk;
  logic       n_rst;
  logic       vld [3];
  logic [7:0] dat [3];
  logic       rdy [3];
  logic       ld  [3];
  logic       sh  [3];
  logic       bz  [3];
  logic       dn  [3];
  logic [9:0]  pin0;
  logic [10:0] pin1;
  logic [2:0]  pin2;
  logic [15:0] pin [3];
  logic [15:0] sr  [3];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int t0 [3] = '{-1, -1, -1};
  logic [15:0] ef [3] = '{16'h03ff, 16'h07ff, 16'h0007};

  typedef struct {
    logic [7:0]  data;
    logic [9:0]  frame_np;
    logic [10:0] frame_p;
  } vec_t;

  pts_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(10), .PARITY_EN(0)) u0 (
    .clk(clk), .n_rst(n_rst), .tx_valid(vld[0]), .tx_data(dat[0]),
    .tx_ready(rdy[0]), .load_enable(ld[0]), .shift_enable(sh[0]),
    .parallel_in(pin0), .busy(bz[0]), .frame_done(dn[0]));

  pts_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(10), .PARITY_EN(1)) u1 (
    .clk(clk), .n_rst(n_rst), .tx_valid(vld[1]), .tx_data(dat[1]),
    .tx_ready(rdy[1]), .load_enable(ld[1]), .shift_enable(sh[1]),
    .parallel_in(pin1), .busy(bz[1]), .frame_done(dn[1]));

  pts_tx_ctrl #(.DATA_BITS(1), .CLKS_PER_BIT(2), .PARITY_EN(0)) u2 (
    .clk(clk), .n_rst(n_rst), .tx_valid(vld[2]), .tx_data(dat[2][0:0]),
    .tx_ready(rdy[2]), .load_enable(ld[2]), .shift_enable(sh[2]),
    .parallel_in(pin2), .busy(bz[2]), .frame_done(dn[2]));

  assign pin[0] = {6'd0, pin0};
  assign pin[1] = {5'd0, pin1};
  assign pin[2] = {13'd0, pin2};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fb(input int id);
    case (id)
      0: fb = 10;
      1: fb = 11;
      default: fb = 3;
    endcase
  endfunction

  function automatic int cb(input int id);
    cb = (id == 2) ? 2 : 10;
  endfunction

  function automatic int db(input int id);
    db = (id == 2) ? 1 : 8;
  endfunction

  function automatic int pb(input int id);
    pb = (id == 1) ? 1 : 0;
  endfunction

  function automatic logic [15:0] ones(input int n);
    ones = 16'((32'd1 << n) - 1);
  endfunction

  // Frame from the framing rule: start 0, data LSB first, even parity, stop 1.
  function automatic logic [15:0] make_frame(input int id, input logic [7:0] d);
    logic [15:0] f;
    logic p;
    f = '0;
    p = 1'b0;
    for (int i = 0; i < db(id); i++) begin
      f[i+1] = d[i];
      p = p ^ d[i];
    end
    if (pb(id) != 0) f[db(id)+1] = p;
    f[db(id)+1+pb(id)] = 1'b1;
    return f;
  endfunction

  // Behavioural shifter: load, or shift right filling with 1s.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 3; i++) sr[i] <= 16'hffff;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ld[i]) sr[i] <= pin[i];
        else if (sh[i]) sr[i] <= (sr[i] >> 1) | (16'h1 << (fb(i) - 1));
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, id, cyc, act, exp);
  endtask

  // Per-cycle reference model for one instance.
  task automatic mon(input int id);
    int f, c, rel, last;
    logic e_ser;
    f = fb(id);
    c = cb(id);
    last = 2 + f * c;
    if (!n_rst) begin
      t0[id] = -1;
      ef[id] = ones(f);
      chk("rst_ready", id, 32'(rdy[id]), 1);
      chk("rst_load", id, 32'(ld[id]), 0);
      chk("rst_shift", id, 32'(sh[id]), 0);
      chk("rst_busy", id, 32'(bz[id]), 0);
      chk("rst_done", id, 32'(dn[id]), 0);
      chk("rst_pin", id, 32'(pin[id]), 32'(ones(f)));
      return;
    end
    rel = (t0[id] >= 0) ? cyc - t0[id] : -1;
    e_ser = 1'b1;
    if (rel >= 2 && rel <= 1 + f * c) e_ser = ef[id][(rel - 2) / c];
    chk("ready", id, 32'(rdy[id]), 32'(t0[id] < 0));
    chk("load", id, 32'(ld[id]), 32'(rel == 1));
    chk("shift", id, 32'(sh[id]), 32'(rel >= 2 && rel <= 1 + f * c && ((rel - 1) % c) == 0));
    chk("busy", id, 32'(bz[id]), 32'(rel >= 1));
    chk("done", id, 32'(dn[id]), 32'(rel == last));
    chk("pin", id, 32'(pin[id]), 32'(ef[id]));
    chk("serial", id, 32'(sr[id][0]), 32'(e_ser));
    if (rel == last) begin
      t0[id] = -1;
    end else if (t0[id] < 0 && vld[id]) begin
      t0[id] = cyc;
      ef[id] = make_frame(id, dat[id]);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int id, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    vld[id] = 1'b1;
    dat[id] = d;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = rdy[id];
    end
    if (!ok) chk("accept_timeout", id, 0, 1);
    @(posedge clk); #1;
    vld[id] = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = rdy[id];
    end
    if (!ok) chk("idle_timeout", id, 0, 1);
    @(posedge clk); #1;
  endtask

  // Accepts a word and records event timing relative to the accept cycle.
  task automatic timing_seq(input int id, input logic [7:0] d, input int e_n,
                            input int e_first, input int e_last, input int e_done,
                            input int e_rdy, input logic [15:0] e_frame);
    int n, first, lst, done_at, rdy_at;
    n = 0; first = -1; lst = -1; done_at = -1; rdy_at = -1;
    send(id, d);
    for (int r = 1; r <= e_rdy; r++) begin
      @(negedge clk);
      if (r == 1) begin
        chk("t_load", id, 32'(ld[id]), 1);
        chk("t_frame", id, 32'(pin[id]), 32'(e_frame));
      end
      if (sh[id]) begin
        n++;
        if (first < 0) first = r;
        lst = r;
      end
      if (dn[id] && done_at < 0) done_at = r;
      if (rdy[id] && rdy_at < 0) rdy_at = r;
    end
    chk("t_nshift", id, n, e_n);
    chk("t_first_shift", id, first, e_first);
    chk("t_last_shift", id, lst, e_last);
    chk("t_done_at", id, done_at, e_done);
    chk("t_ready_at", id, rdy_at, e_rdy);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl [6];

  initial begin
    int n;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    tbl[0] = '{8'hA5, 10'h34A, 11'h54A};
    tbl[1] = '{8'h07, 10'h20E, 11'h60E};
    tbl[2] = '{8'h00, 10'h200, 11'h400};
    tbl[3] = '{8'hFF, 10'h3FE, 11'h5FE};
    tbl[4] = '{8'h80, 10'h300, 11'h700};
    tbl[5] = '{8'h01, 10'h202, 11'h602};

    // Table: captured frame per configuration.
    for (int i = 0; i < 6; i++) begin
      send(0, tbl[i].data);
      @(negedge clk);
      chk("tbl_frame_np", 0, 32'(pin[0]), 32'(tbl[i].frame_np));
      wait_idle(0);
      send(1, tbl[i].data);
      @(negedge clk);
      chk("tbl_frame_p", 1, 32'(pin[1]), 32'(tbl[i].frame_p));
      wait_idle(1);
    end

    // Frame timing, parity frame, and minimum configuration.
    timing_seq(0, 8'hA5, 10, 11, 101, 102, 103, 16'h034A);
    timing_seq(1, 8'h07, 11, 11, 111, 112, 113, 16'h060E);
    timing_seq(2, 8'h01, 3, 3, 7, 8, 9, 16'h0006);

    // Back-to-back with tx_valid held high.
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = rdy[0];
    end
    if (!ok) chk("b2b_accept_timeout", 0, 0, 1);
    @(posedge clk); #1;
    dat[0] = 8'hFF;
    n = -1;
    for (int k = 1; k <= 200 && n < 0; k++) begin
      @(negedge clk);
      if (rdy[0]) n = k;
    end
    chk("b2b_gap", 0, n, 103);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk("b2b_load", 0, 32'(ld[0]), 1);
    wait_idle(0);

    // Requester noise during SEND.
    send(0, 8'h3C);
    repeat (30) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      vld[0] = k[0];
      dat[0] = 8'($urandom);
      @(negedge clk);
      chk("noise_ready", 0, 32'(rdy[0]), 0);
      chk("noise_load", 0, 32'(ld[0]), 0);
      @(posedge clk); #1;
    end
    vld[0] = 1'b0;
    wait_idle(0);

    // Reset after the 4th shift.
    send(0, 8'h5A);
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clk);
      if (sh[0]) n++;
    end
    chk("mid_shifts", 0, n, 4);
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 0, 32'(bz[0]), 0);
    chk("mid_ready", 0, 32'(rdy[0]), 1);
    chk("mid_pin", 0, 32'(pin[0]), 32'h3FF);
    chk("mid_line", 0, 32'(sr[0][0]), 1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    timing_seq(0, 8'h96, 10, 11, 101, 102, 103, 16'h032C);

    // Random traffic on all three instances.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        vld[i] = ($urandom_range(0, 3) == 0);
        dat[i] = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    for (int i = 0; i < 3; i++) wait_idle(i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
